// File: rtl/rf_dump_reader_pkg.sv
// Shared types and width defaults for the register-file dump reader.
// State encodings are fixed so they stay stable for on-board debug probes.
package rf_dump_reader_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_e;

endpackage

// File: rtl/rf_dump_reader_if.sv
// Bundle of dump-request, register-file read port and output stream signals.
// The master modport is the dump reader; the slave modport is its environment.
interface rf_dump_reader_if
    import rf_dump_reader_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
);

    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] first_idx;
    logic [ADDR_W-1:0] last_idx;
    logic [ADDR_W-1:0] rf_rR;
    logic [DATA_W-1:0] rf_rD;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_idx;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              cpu_hold;
    logic              done;

    modport master (
        input  start, abort, first_idx, last_idx, rf_rD, out_ready,
        output rf_rR, out_valid, out_idx, out_data, out_last, cpu_hold, done
    );

    modport slave (
        output start, abort, first_idx, last_idx, rf_rD, out_ready,
        input  rf_rR, out_valid, out_idx, out_data, out_last, cpu_hold, done
    );

endinterface

// File: rtl/rf_dump_reader.sv
// Walks a wrapping range of register-file entries through one async read port
// and streams (index, data) pairs out over valid/ready while holding the core.
module rf_dump_reader
    import rf_dump_reader_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    rf_dump_reader_if.master   dump
);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cursor_q, cursor_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_idx_q, out_idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cursor_q    <= '0;
            end_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            end_q       <= end_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        end_d       = end_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        case (state_q)
            ST_IDLE: begin
                if (dump.start) begin
                    cursor_d = dump.first_idx;
                    end_d    = dump.last_idx;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                out_data_d  = dump.rf_rD;
                out_idx_d   = cursor_q;
                out_last_d  = (cursor_q == end_q);
                out_valid_d = 1'b1;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (out_valid_q && dump.out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        cursor_d = cursor_q + ADDR_W'(1);
                        state_d  = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over a same-cycle handshake and leaves the cursor where it was.
        if (dump.abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            cursor_d    = cursor_q;
        end
    end

    assign dump.rf_rR     = cursor_q;
    assign dump.out_valid = out_valid_q;
    assign dump.out_idx   = out_idx_q;
    assign dump.out_data  = out_data_q;
    assign dump.out_last  = out_last_q;
    assign dump.cpu_hold  = (state_q != ST_IDLE);
    assign dump.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_rf_dump_reader.sv
// Randomized scenario bench for rf_dump_reader; expected words come from a
// range/wrap model over a behavioural register-file array.
module tb_rf_dump_reader;

    logic clk;
    logic rst_n;

    rf_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) dif ();

    rf_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dump  (dif)
    );

    logic [31:0] rf_mem [32];
    assign dif.rf_rD = rf_mem[dif.rf_rR];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [4:0]  obs_idx[$];
    logic [31:0] obs_data[$];
    logic        obs_last[$];
    logic [4:0]  exp_idx[$];
    logic [31:0] exp_data[$];
    logic        exp_last[$];

    int   stable_err, gap_err, hold_err, valid_latency, stall_total;
    bit   timed_out, injected;
    logic done_seen1, done_seen2, hold_in_done, hold_after_done;

    // Model: word count is ((last - first) mod 32) + 1, indices walk upward mod 32.
    task automatic build_expected(input logic [4:0] f, input logic [4:0] l);
        int n;
        exp_idx.delete(); exp_data.delete(); exp_last.delete();
        n = (((int'(l) - int'(f)) % 32) + 32) % 32 + 1;
        for (int k = 0; k < n; k++) begin
            exp_idx.push_back(5'((int'(f) + k) % 32));
            exp_data.push_back(rf_mem[(int'(f) + k) % 32]);
            exp_last.push_back(k == n - 1);
        end
    endtask

    task automatic randomize_rf();
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        rf_mem[0] = 32'h0;
    endtask

    // Starts a dump and records every accepted word plus timing observations.
    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int ready_pct,
                            input int stall_word, input bit inject_start);
        bit   finished, prev_stall;
        int   since_hs, stall_cnt;
        logic [4:0]  p_idx;
        logic [31:0] p_data;
        logic        p_last;
        obs_idx.delete(); obs_data.delete(); obs_last.delete();
        stable_err = 0; gap_err = 0; hold_err = 0; valid_latency = -1; stall_total = 0;
        injected = 0; finished = 0; prev_stall = 0; since_hs = -1; stall_cnt = 0;
        p_idx = '0; p_data = '0; p_last = 1'b0;
        @(negedge clk);
        dif.start = 1'b1; dif.first_idx = f; dif.last_idx = l; dif.out_ready = 1'b0;
        @(negedge clk);
        dif.start = 1'b0; dif.first_idx = 5'($urandom); dif.last_idx = 5'($urandom);
        for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
            if (cyc > 1) @(negedge clk);
            dif.start = 1'b0;
            if (dif.cpu_hold !== 1'b1) hold_err++;
            if (dif.out_valid === 1'b1 && valid_latency < 0) valid_latency = cyc;
            if (prev_stall && (dif.out_valid !== 1'b1 || dif.out_idx !== p_idx ||
                               dif.out_data !== p_data || dif.out_last !== p_last))
                stable_err++;
            if (since_hs >= 0) since_hs++;
            if (dif.out_valid === 1'b1 && since_hs > 0) begin
                if (since_hs != 2) gap_err++;
                since_hs = -1;
            end
            if (dif.out_valid === 1'b1 && obs_idx.size() == stall_word && stall_cnt < 5) begin
                dif.out_ready = 1'b0;
                stall_cnt++;
                stall_total++;
            end else begin
                dif.out_ready = ($urandom_range(99) < ready_pct);
            end
            if (inject_start && !injected && obs_idx.size() == 1 && dif.out_valid === 1'b1) begin
                dif.start = 1'b1;
                dif.first_idx = f + 5'd9;
                dif.last_idx = l + 5'd3;
                injected = 1;
            end
            prev_stall = (dif.out_valid === 1'b1) && !dif.out_ready;
            p_idx = dif.out_idx; p_data = dif.out_data; p_last = dif.out_last;
            if (dif.out_valid === 1'b1 && dif.out_ready) begin
                obs_idx.push_back(dif.out_idx);
                obs_data.push_back(dif.out_data);
                obs_last.push_back(dif.out_last);
                since_hs = 0;
                if (dif.out_last === 1'b1) finished = 1;
            end
        end
        timed_out = !finished;
        @(negedge clk);
        dif.start = 1'b0; dif.out_ready = 1'b0;
        done_seen1 = dif.done; hold_in_done = dif.cpu_hold;
        @(negedge clk);
        done_seen2 = dif.done; hold_after_done = dif.cpu_hold;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dif.start = 1'b0; dif.abort = 1'b0; dif.first_idx = '0; dif.last_idx = '0;
        dif.out_ready = 1'b0;
        randomize_rf();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({dif.rf_rR, dif.out_valid, dif.out_idx, dif.out_data, dif.out_last} !== 40'h0) begin
            n_fails++;
            $display("[TB] FAIL reset_outputs: got rR=%0h v=%0b idx=%0h data=%0h last=%0b, expected all zero",
                     dif.rf_rR, dif.out_valid, dif.out_idx, dif.out_data, dif.out_last);
        end
        n_checks++;
        if ({dif.cpu_hold, dif.done} !== 2'b00) begin
            n_fails++;
            $display("[TB] FAIL reset_hold_done: got hold=%0b done=%0b, expected 0 0", dif.cpu_hold, dif.done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        dif.abort = 1'b1;
        @(negedge clk);
        dif.abort = 1'b0;
        n_checks++;
        if ({dif.cpu_hold, dif.done, dif.out_valid} !== 3'b000) begin
            n_fails++;
            $display("[TB] FAIL idle_abort_noop: got hold=%0b done=%0b valid=%0b, expected 0 0 0",
                     dif.cpu_hold, dif.done, dif.out_valid);
        end
    endtask

    task automatic test_basic();
        rf_mem[1] = 32'h11; rf_mem[2] = 32'h22; rf_mem[3] = 32'h33;
        run_dump(5'd0, 5'd3, 100, -1, 0);
        build_expected(5'd0, 5'd3);
        n_checks++;
        if (obs_idx.size() !== 4 || timed_out) begin
            n_fails++;
            $display("[TB] FAIL basic_count: got %0d words (timeout=%0b), expected 4", obs_idx.size(), timed_out);
        end
        for (int k = 0; k < exp_idx.size() && k < obs_idx.size(); k++) begin
            n_checks++;
            if ({obs_idx[k], obs_data[k], obs_last[k]} !== {exp_idx[k], exp_data[k], exp_last[k]}) begin
                n_fails++;
                $display("[TB] FAIL basic_word%0d: got idx=%0d data=%h last=%0b, expected idx=%0d data=%h last=%0b",
                         k, obs_idx[k], obs_data[k], obs_last[k], exp_idx[k], exp_data[k], exp_last[k]);
            end
        end
        n_checks++;
        if (valid_latency !== 2) begin
            n_fails++;
            $display("[TB] FAIL basic_latency: got first valid at cycle %0d, expected 2", valid_latency);
        end
        n_checks++;
        if ({done_seen1, done_seen2, hold_in_done, hold_after_done} !== 4'b1010) begin
            n_fails++;
            $display("[TB] FAIL basic_done_hold: got done=%0b,%0b hold=%0b,%0b, expected done=1,0 hold=1,0",
                     done_seen1, done_seen2, hold_in_done, hold_after_done);
        end
        n_checks++;
        if (hold_err !== 0 || gap_err !== 0) begin
            n_fails++;
            $display("[TB] FAIL basic_hold_gap: got hold_err=%0d gap_err=%0d, expected 0 0", hold_err, gap_err);
        end
    endtask

    task automatic test_wrap_and_single();
        randomize_rf();
        run_dump(5'd30, 5'd1, 70, -1, 0);
        build_expected(5'd30, 5'd1);
        n_checks++;
        if (obs_idx.size() !== 4 || timed_out) begin
            n_fails++;
            $display("[TB] FAIL wrap_count: got %0d words, expected 4", obs_idx.size());
        end
        for (int k = 0; k < exp_idx.size() && k < obs_idx.size(); k++) begin
            n_checks++;
            if ({obs_idx[k], obs_data[k], obs_last[k]} !== {exp_idx[k], exp_data[k], exp_last[k]}) begin
                n_fails++;
                $display("[TB] FAIL wrap_word%0d: got idx=%0d data=%h last=%0b, expected idx=%0d data=%h last=%0b",
                         k, obs_idx[k], obs_data[k], obs_last[k], exp_idx[k], exp_data[k], exp_last[k]);
            end
        end
        rf_mem[7] = 32'hDEADBEEF;
        run_dump(5'd7, 5'd7, 60, -1, 0);
        n_checks++;
        if (obs_idx.size() !== 1 || timed_out) begin
            n_fails++;
            $display("[TB] FAIL single_count: got %0d words, expected 1", obs_idx.size());
        end else begin
            n_checks++;
            if ({obs_idx[0], obs_data[0], obs_last[0]} !== {5'd7, 32'hDEADBEEF, 1'b1}) begin
                n_fails++;
                $display("[TB] FAIL single_word: got idx=%0d data=%h last=%0b, expected idx=7 data=deadbeef last=1",
                         obs_idx[0], obs_data[0], obs_last[0]);
            end
        end
        n_checks++;
        if ({done_seen1, done_seen2} !== 2'b10) begin
            n_fails++;
            $display("[TB] FAIL single_done: got %0b,%0b, expected 1,0", done_seen1, done_seen2);
        end
    endtask

    task automatic test_backpressure();
        randomize_rf();
        run_dump(5'd10, 5'd15, 100, 2, 0);
        build_expected(5'd10, 5'd15);
        n_checks++;
        if (stall_total !== 5 || stable_err !== 0) begin
            n_fails++;
            $display("[TB] FAIL bp_stable: got stalls=%0d unstable=%0d, expected 5 0", stall_total, stable_err);
        end
        n_checks++;
        if (gap_err !== 0) begin
            n_fails++;
            $display("[TB] FAIL bp_gap: got %0d bad gaps, expected 0", gap_err);
        end
        n_checks++;
        if (obs_idx.size() !== exp_idx.size() || timed_out) begin
            n_fails++;
            $display("[TB] FAIL bp_count: got %0d words, expected %0d", obs_idx.size(), exp_idx.size());
        end
        for (int k = 0; k < exp_idx.size() && k < obs_idx.size(); k++) begin
            n_checks++;
            if ({obs_idx[k], obs_data[k], obs_last[k]} !== {exp_idx[k], exp_data[k], exp_last[k]}) begin
                n_fails++;
                $display("[TB] FAIL bp_word%0d: got idx=%0d data=%h, expected idx=%0d data=%h",
                         k, obs_idx[k], obs_data[k], exp_idx[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_start_ignored_and_full();
        randomize_rf();
        run_dump(5'd20, 5'd24, 80, -1, 1);
        build_expected(5'd20, 5'd24);
        n_checks++;
        if (!injected || obs_idx.size() !== exp_idx.size() || timed_out) begin
            n_fails++;
            $display("[TB] FAIL busy_start_count: got %0d words (injected=%0b), expected %0d",
                     obs_idx.size(), injected, exp_idx.size());
        end
        for (int k = 0; k < exp_idx.size() && k < obs_idx.size(); k++) begin
            n_checks++;
            if ({obs_idx[k], obs_data[k], obs_last[k]} !== {exp_idx[k], exp_data[k], exp_last[k]}) begin
                n_fails++;
                $display("[TB] FAIL busy_start_word%0d: got idx=%0d data=%h, expected idx=%0d data=%h",
                         k, obs_idx[k], obs_data[k], exp_idx[k], exp_data[k]);
            end
        end
        randomize_rf();
        run_dump(5'd5, 5'd4, 70, -1, 0);
        build_expected(5'd5, 5'd4);
        n_checks++;
        if (obs_idx.size() !== 32 || timed_out) begin
            n_fails++;
            $display("[TB] FAIL full_count: got %0d words, expected 32", obs_idx.size());
        end
        for (int k = 0; k < exp_idx.size() && k < obs_idx.size(); k++) begin
            n_checks++;
            if ({obs_idx[k], obs_data[k], obs_last[k]} !== {exp_idx[k], exp_data[k], exp_last[k]}) begin
                n_fails++;
                $display("[TB] FAIL full_word%0d: got idx=%0d data=%h last=%0b, expected idx=%0d data=%h last=%0b",
                         k, obs_idx[k], obs_data[k], obs_last[k], exp_idx[k], exp_data[k], exp_last[k]);
            end
        end
        n_checks++;
        if (done_seen1 !== 1'b1 || hold_err !== 0) begin
            n_fails++;
            $display("[TB] FAIL full_done: got done=%0b hold_err=%0d, expected 1 0", done_seen1, hold_err);
        end
    endtask

    task automatic test_abort();
        int  hs;
        int  done_hits;
        bit  reached;
        randomize_rf();
        hs = 0; done_hits = 0; reached = 0;
        @(negedge clk);
        dif.start = 1'b1; dif.first_idx = 5'd0; dif.last_idx = 5'd9; dif.out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && !reached; cyc++) begin
            @(negedge clk);
            dif.start = 1'b0;
            dif.out_ready = 1'b1;
            if (dif.out_valid === 1'b1) begin
                if (hs == 2) begin
                    dif.abort = 1'b1;
                    reached = 1;
                end else begin
                    hs++;
                end
            end
        end
        @(negedge clk);
        dif.abort = 1'b0; dif.out_ready = 1'b0;
        n_checks++;
        if (!reached || {dif.out_valid, dif.cpu_hold, dif.done} !== 3'b000) begin
            n_fails++;
            $display("[TB] FAIL abort_idle: got reached=%0b valid=%0b hold=%0b done=%0b, expected 1 0 0 0",
                     reached, dif.out_valid, dif.cpu_hold, dif.done);
        end
        repeat (4) begin
            @(negedge clk);
            if (dif.done !== 1'b0 || dif.cpu_hold !== 1'b0) done_hits++;
        end
        n_checks++;
        if (done_hits !== 0) begin
            n_fails++;
            $display("[TB] FAIL abort_no_done: got %0d active cycles, expected 0", done_hits);
        end
        run_dump(5'd12, 5'd14, 90, -1, 0);
        build_expected(5'd12, 5'd14);
        n_checks++;
        if (obs_idx.size() !== 3 || timed_out || done_seen1 !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL abort_restart_count: got %0d words done=%0b, expected 3 done=1",
                     obs_idx.size(), done_seen1);
        end
        for (int k = 0; k < exp_idx.size() && k < obs_idx.size(); k++) begin
            n_checks++;
            if ({obs_idx[k], obs_data[k], obs_last[k]} !== {exp_idx[k], exp_data[k], exp_last[k]}) begin
                n_fails++;
                $display("[TB] FAIL abort_restart_word%0d: got idx=%0d data=%h, expected idx=%0d data=%h",
                         k, obs_idx[k], obs_data[k], exp_idx[k], exp_data[k]);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        int bad;
        bad = 0;
        @(negedge clk);
        dif.start = 1'b1; dif.first_idx = 5'd9; dif.last_idx = 5'd12;
        @(negedge clk);
        dif.start = 1'b0;
        n_checks++;
        if (dif.cpu_hold !== 1'b1 || dif.rf_rR !== 5'd9) begin
            n_fails++;
            $display("[TB] FAIL mid_reset_pre: got hold=%0b rR=%0d, expected 1 9", dif.cpu_hold, dif.rf_rR);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dif.rf_rR, dif.out_valid, dif.out_idx, dif.out_data, dif.out_last, dif.cpu_hold, dif.done} !== 42'h0) begin
            n_fails++;
            $display("[TB] FAIL mid_reset_async: got rR=%0d v=%0b idx=%0d data=%h last=%0b hold=%0b done=%0b, expected all zero",
                     dif.rf_rR, dif.out_valid, dif.out_idx, dif.out_data, dif.out_last, dif.cpu_hold, dif.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (dif.done !== 1'b0 || dif.cpu_hold !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fails++;
            $display("[TB] FAIL mid_reset_idle: got %0d non-idle cycles, expected 0", bad);
        end
        randomize_rf();
        run_dump(5'd27, 5'd3, 75, -1, 0);
        build_expected(5'd27, 5'd3);
        n_checks++;
        if (obs_idx.size() !== 9 || timed_out) begin
            n_fails++;
            $display("[TB] FAIL post_reset_count: got %0d words, expected 9", obs_idx.size());
        end
        for (int k = 0; k < exp_idx.size() && k < obs_idx.size(); k++) begin
            n_checks++;
            if ({obs_idx[k], obs_data[k], obs_last[k]} !== {exp_idx[k], exp_data[k], exp_last[k]}) begin
                n_fails++;
                $display("[TB] FAIL post_reset_word%0d: got idx=%0d data=%h, expected idx=%0d data=%h",
                         k, obs_idx[k], obs_data[k], exp_idx[k], exp_data[k]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap_and_single();
        test_backpressure();
        test_start_ignored_and_full();
        test_abort();
        test_reset_mid_dump();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
